pwm_capture: RTL and testbench
==============================

PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CNT_W, default 16: width of the cycle counter and of the reported high/period counts.
REQ-002 clk  input  1  single clock for all state; rising edge active.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 en  input  1  synchronous enable; 1 = measure, 0 = hold.
REQ-005 pwm_in  input  1  asynchronous PWM signal under measurement.
REQ-006 high_cnt  output  CNT_W  clk cycles pwm_in was high in the last measured period.
REQ-007 period_cnt  output  CNT_W  clk cycles between consecutive rising edges in the last measured period.
REQ-008 duty  output  4  floor(10*high_cnt/period_cnt), range 0..10, in 10% steps.
REQ-009 valid  output  1  one-cycle strobe; all result outputs updated in the same cycle.
REQ-010 stuck  output  1  1 = last result came from a timeout, not a full period.

Function
REQ-011 pwm_in SHALL pass a 2-flop synchronizer (s1, s2) and a third flop s3; rise = s2 & ~s3, fall = ~s2 & s3.
REQ-012 FSM states SHALL be WAIT_RISE, HIGH, LOW, DIV; reset state WAIT_RISE.
REQ-013 WAIT_RISE: on rise, cnt <= 1 and go to HIGH; otherwise cnt increments.
REQ-014 HIGH: each cycle cnt increments; on fall, latch hi = cnt and go to LOW.
REQ-015 LOW: each cycle cnt increments; on rise, latch per = cnt and go to DIV.
REQ-016 Count accuracy: a synchronized high of H cycles within a period of P cycles SHALL give hi = H and per = P.
REQ-017 Rise/fall events SHALL be ignored while in DIV; the period following a DIV is not measured. Results therefore cover at most every other input period.
REQ-018 DIV entry: acc <= 10*hi, width CNT_W+4, and q <= 0.
REQ-019 DIV iteration: each cycle, if acc >= per then acc <= acc - per and q <= q + 1.
REQ-020 DIV exit: when acc < per, the block SHALL do all of the following in one cycle: duty <= q, high_cnt <= hi, period_cnt <= per, stuck <= 0, valid = 1, return to WAIT_RISE with cnt <= 0.
REQ-021 DIV duration SHALL be q+1 cycles, at most 11.
REQ-022 Timeout: if cnt reaches 2^CNT_W-1 in WAIT_RISE, HIGH or LOW, the block SHALL, in that cycle:
- set duty <= 10 if s2 = 1, else duty <= 0;
- set high_cnt <= 0, period_cnt <= 0, stuck <= 1, valid = 1;
- set cnt <= 0 and go to WAIT_RISE.
REQ-023 cnt SHALL never wrap: timeout takes priority over rise/fall in the same cycle.
REQ-024 en = 0 SHALL force WAIT_RISE with cnt = 0 and valid = 0, and result outputs SHALL hold. Synchronizer flops keep running.
REQ-025 en deasserting mid-measurement or mid-DIV SHALL discard the partial result with no valid.
REQ-026 valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 rst_n low SHALL immediately clear s1, s2, s3, cnt, hi, per, acc, q, high_cnt, period_cnt, duty, valid and stuck to 0, and set state to WAIT_RISE.
REQ-028 rst_n asserted mid-measurement or mid-DIV SHALL abandon that measurement; the first valid after release requires a full new period.
REQ-029 Reset release is synchronized externally; the block needs no extra deassertion logic.

Verification
REQ-030 Reset check: hold rst_n=0 with pwm_in toggling -> all outputs 0. Release, then feed period 10, high 5 -> first valid shows high_cnt=5, period_cnt=10, duty=5, stuck=0.
REQ-031 Duty sweep: period 10, high 0..10 in steps of 1; high 0 and 10 are constant levels. Expected:
- high 1..9 -> duty = high, one valid every other period;
- high 0 / 10 -> timeout results duty=0 / duty=10, stuck=1.
REQ-032 Rounding: period 7, high 3 -> duty=4, DIV lasts 5 cycles. Period 3, high 1 -> duty=3.
REQ-033 Timeout: CNT_W=8, pwm_in held high -> valid with duty=10, stuck=1, period_cnt=0. Then apply period 10, high 2 -> duty=2, stuck=0.
REQ-034 Enable: drop en mid-HIGH for 20 cycles -> no valid during or just after. With en=1 again, results match the input after one full period.
REQ-035 Async reset mid-DIV: rst_n pulses low, not aligned to clk -> outputs clear immediately, no valid from the aborted division.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM measurement: synchronizes pwm_in, counts high time and period between rising edges,
// then derives duty in 10% steps with a restoring divider. Idle levels are reported as timeouts.
module pwm_capture #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [3:0]       duty,
    output logic             valid,
    output logic             stuck
);

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW,
        DIV
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              s1_q, s2_q, s3_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  hi_q, hi_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic [CNT_W+3:0]  acc_q, acc_d;
    logic [3:0]        q_q, q_d;
    logic [CNT_W-1:0]  high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0]  period_cnt_q, period_cnt_d;
    logic [3:0]        duty_q, duty_d;
    logic              valid_q, valid_d;
    logic              stuck_q, stuck_d;

    logic              rise;
    logic              fall;
    logic              cnt_max;
    logic [CNT_W+3:0]  hi_ext;
    logic [CNT_W+3:0]  hi_x10;
    logic [CNT_W+3:0]  per_ext;

    assign rise    = s2_q & ~s3_q;
    assign fall    = ~s2_q & s3_q;
    assign cnt_max = (cnt_q == '1);
    assign hi_ext  = {4'b0000, hi_q};
    assign hi_x10  = (hi_ext << 3) + (hi_ext << 1);
    assign per_ext = {4'b0000, per_q};

    // Synchronizer runs regardless of en so edge detection is valid immediately on re-enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= pwm_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_RISE;
            cnt_q        <= '0;
            hi_q         <= '0;
            per_q        <= '0;
            acc_q        <= '0;
            q_q          <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty_q       <= '0;
            valid_q      <= 1'b0;
            stuck_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            hi_q         <= hi_d;
            per_q        <= per_d;
            acc_q        <= acc_d;
            q_q          <= q_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            duty_q       <= duty_d;
            valid_q      <= valid_d;
            stuck_q      <= stuck_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        hi_d         = hi_q;
        per_d        = per_q;
        acc_d        = acc_q;
        q_d          = q_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        duty_d       = duty_q;
        valid_d      = 1'b0;
        stuck_d      = stuck_q;

        if (!en) begin
            state_d = WAIT_RISE;
            cnt_d   = '0;
        end else if ((state_q != DIV) && cnt_max) begin
            // Saturated counter: report the static level instead of wrapping.
            duty_d       = s2_q ? 4'd10 : 4'd0;
            high_cnt_d   = '0;
            period_cnt_d = '0;
            stuck_d      = 1'b1;
            valid_d      = 1'b1;
            cnt_d        = '0;
            state_d      = WAIT_RISE;
        end else begin
            unique case (state_q)
                WAIT_RISE: begin
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = HIGH;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HIGH: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (fall) begin
                        hi_d    = cnt_q;
                        state_d = LOW;
                    end
                end
                LOW: begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (rise) begin
                        per_d   = cnt_q;
                        acc_d   = hi_x10;
                        q_d     = '0;
                        state_d = DIV;
                    end
                end
                DIV: begin
                    if (acc_q >= per_ext) begin
                        acc_d = acc_q - per_ext;
                        q_d   = q_q + 4'd1;
                    end else begin
                        duty_d       = q_q;
                        high_cnt_d   = hi_q;
                        period_cnt_d = per_q;
                        stuck_d      = 1'b0;
                        valid_d      = 1'b1;
                        cnt_d        = '0;
                        state_d      = WAIT_RISE;
                    end
                end
                default: begin
                    state_d = WAIT_RISE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign duty       = duty_q;
    assign valid      = valid_q;
    assign stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized and directed bench for pwm_capture; expected results come from an
// event-level model of which periods get measured and when each result appears.
module tb_pwm_capture;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       duty;
    logic             valid;
    logic             stuck;

    pwm_capture #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .duty       (duty),
        .valid      (valid),
        .stuck      (stuck)
    );

    always #5 clk = ~clk;

    typedef struct {
        int hi;
        int per;
        int dty;
        int stk;
        int at;
    } exp_t;

    exp_t exp_q[$];
    int   sh[$];
    int   sp[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   prev_valid = 0;
    exp_t e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every valid strobe is consumed against the model's queue of predicted results.
    always @(negedge clk) begin
        if (valid) begin
            check("valid_gap", prev_valid, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", int'(valid), 0);
            end else begin
                e = exp_q.pop_front();
                check("high_cnt", int'(high_cnt), e.hi);
                check("period_cnt", int'(period_cnt), e.per);
                check("duty", int'(duty), e.dty);
                check("stuck", int'(stuck), e.stk);
                if (e.at >= 0) check("valid_time", cyc, e.at);
            end
        end
        prev_valid = int'(valid);
    end

    task automatic drive(input logic v);
        @(posedge clk);
        #1;
        pwm_in = v;
    endtask

    task automatic en_cycle();
        @(posedge clk);
        #1 en = 1'b0;
        @(posedge clk);
        #1 en = 1'b1;
    endtask

    task automatic add_periods(input int n, input int h, input int p);
        for (int i = 0; i < n; i++) begin
            sh.push_back(h);
            sp.push_back(p);
        end
    endtask

    // A rise starts a measurement only when the block is idle; the next rise closes it,
    // and the block is busy for duty+1 divider cycles after that.
    task automatic run_stream();
        int  t;
        int  t_start;
        int  h_meas;
        int  idle;
        int  q;
        bit  meas;
        exp_t x;
        idle = 0;
        meas = 1'b0;
        t_start = 0;
        h_meas = 0;
        for (int i = 0; i < 4; i++) drive(1'b0);
        for (int k = 0; k < sp.size(); k++) begin
            for (int j = 0; j < sp[k]; j++) begin
                drive(j < sh[k]);
                if (j == 0) begin
                    t = cyc;
                    if (meas) begin
                        q = (10 * h_meas) / (t - t_start);
                        x.hi  = h_meas;
                        x.per = t - t_start;
                        x.dty = q;
                        x.stk = 0;
                        x.at  = t + q + 4;
                        exp_q.push_back(x);
                        idle = t + q + 2;
                        meas = 1'b0;
                    end else if (t >= idle) begin
                        meas = 1'b1;
                        t_start = t;
                        h_meas = sh[k];
                    end
                end
            end
        end
        for (int i = 0; i < 20; i++) drive(1'b0);
        check("drain", exp_q.size(), 0);
        exp_q.delete();
        en_cycle();
        sh.delete();
        sp.delete();
    endtask

    task automatic expect_timeout(input int d, input string tag);
        exp_t x;
        x.hi = 0;
        x.per = 0;
        x.dty = d;
        x.stk = 1;
        x.at = -1;
        exp_q.push_back(x);
        for (int i = 0; i < 600; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        @(negedge clk);
        check(tag, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst_n  = 1'b0;
        en     = 1'b1;
        pwm_in = 1'b0;

        for (int i = 0; i < 6; i++) drive(logic'(i % 2 == 0));
        #2;
        check("rst_high_cnt", int'(high_cnt), 0);
        check("rst_period_cnt", int'(period_cnt), 0);
        check("rst_duty", int'(duty), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_stuck", int'(stuck), 0);
        rst_n = 1'b1;

        add_periods(5, 5, 10);
        run_stream();

        expect_timeout(0, "timeout_low");

        for (int h = 1; h <= 9; h++) begin
            add_periods(6, h, 10);
            run_stream();
        end

        drive(1'b1);
        expect_timeout(10, "timeout_high");
        drive(1'b0);
        en_cycle();
        add_periods(5, 2, 10);
        run_stream();

        add_periods(5, 3, 7);
        add_periods(5, 1, 3);
        run_stream();

        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 8; k++) begin
                p = $urandom_range(40, 2);
                add_periods(1, $urandom_range(p - 1, 1), p);
            end
            run_stream();
        end

        // Enable dropped while the block is in HIGH; no result may come from that period.
        for (int i = 0; i < 4; i++) drive(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1);
        en = 1'b0;
        for (int i = 0; i < 5; i++) drive(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0);
        for (int i = 0; i < 4; i++) drive(1'b1);
        en = 1'b1;
        drive(1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0);
        add_periods(5, 5, 10);
        run_stream();

        // Reset pulse off the clock edge while the divider is iterating.
        for (int i = 0; i < 4; i++) drive(1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1);
        for (int i = 0; i < 4; i++) drive(1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1);
        #2;
        pwm_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check("arst_high_cnt", int'(high_cnt), 0);
        check("arst_period_cnt", int'(period_cnt), 0);
        check("arst_duty", int'(duty), 0);
        check("arst_valid", int'(valid), 0);
        check("arst_stuck", int'(stuck), 0);
        #13;
        rst_n = 1'b1;
        for (int i = 0; i < 30; i++) drive(1'b0);
        add_periods(4, 4, 9);
        run_stream();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
